seq_detect_param: RTL
=====================

// Module: seq_detect_param
// PURPOSE
//  Runtime-programmable serial bit-pattern detector. Generalises the fixed 1011 detector:
//   - pattern and length are set at run time, up to MAX_LEN bits
//   - input bits are qualified by a valid strobe
//   - overlapping and non-overlapping matching are both supported
//   - matches are tallied in a saturating counter
//  Sits on a serial bit stream, e.g. after a deserialiser or UART RX, and flags frame/sync words.
// PARAMETERS
//  MAX_LEN      8          maximum pattern length in bits (>=2)
//  CNT_W        8          width of match_count
//  RST_PATTERN  8'h0B      pattern loaded at reset (LSB-aligned, MAX_LEN bits)
//  RST_LEN      4          pattern length loaded at reset (1..MAX_LEN)
//  RST_OVERLAP  1          overlap mode loaded at reset
// PORTS  (LW = $clog2(MAX_LEN+1))
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  inp_valid    in   1        inp_bit is sampled only when 1
//  inp_bit      in   1        serial data bit
//  cfg_load     in   1        one-cycle pulse: capture cfg_* and restart detection
//  cfg_pattern  in   MAX_LEN  new pattern, LSB-aligned; bit [len-1] is expected first, bit [0] last
//  cfg_len      in   LW       new length, legal 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping matches, 0 = non-overlapping
//  cnt_clear    in   1        synchronous clear of match_count and cnt_sat
//  seq_seen     out  1        one-cycle pulse per match
//  match_count  out  CNT_W    saturating count of matches
//  cnt_sat      out  1        sticky: match_count has reached all-ones
//  cfg_err      out  1        one-cycle pulse: cfg_load rejected because of an illegal cfg_len
// BEHAVIOUR
//  Reset (reset=0, async)
//   - state=FILL, hist=0, fill=0, pattern/len/overlap = RST_* values
//   - seq_seen=0, match_count=0, cnt_sat=0, cfg_err=0
//  Storage
//   - hist: MAX_LEN-bit shift register; on an accepted bit, hist <= {hist[MAX_LEN-2:0], inp_bit}
//   - fill: 0..len, counts accepted bits since the last restart; saturates at len
//  State machine, two states, advances only on accepted bits (inp_valid=1, cfg_load=0)
//   - FILL:   fill<len; no compare
//             fill reaches len on this bit -> go to DETECT and compare this bit in the same cycle
//   - DETECT: match = (hist_next[len-1:0] == pattern[len-1:0])
//   - After a match:
//       overlap=1 -> stay in DETECT; hist retained
//       overlap=0 -> fill=0, hist=0, state=FILL
//  Latency
//   - seq_seen is registered: high for exactly 1 cycle, the cycle after the clock edge that accepted the final bit
//   - seq_seen=0 in any cycle with no accepted bit
//   - inp_valid gaps of any length are transparent to matching
//  Counter
//   - match_count increments on each match; holds at 2^CNT_W-1
//   - cnt_sat sets in the same cycle match_count reaches all-ones and stays set until cleared
//   - cnt_clear and a match in the same cycle: clear wins, count=0; seq_seen still pulses
//  Configuration
//   - cfg_load with 1<=cfg_len<=MAX_LEN:
//       capture pattern, len and overlap; hist=0, fill=0, state=FILL
//       any bit presented in the same cycle is discarded
//       match_count is not cleared
//   - cfg_load with cfg_len=0 or >MAX_LEN:
//       config, hist, fill and state unchanged
//       cfg_err pulses for 1 cycle (registered); the bit in the same cycle is discarded
//   - Bits of cfg_pattern above len-1 are ignored
//  Edge cases
//   - len=1: every accepted bit equal to pattern[0] is a match
//   - reset asserted mid-stream: all state returns to reset values immediately; partial matches are lost
// TESTING
//  1. Defaults: bits 1,0,1,1,0,1,1 (valid every cycle)
//       -> seq_seen pulses after bit 4 and after bit 7; match_count=2
//  2. cfg_load pattern=0x0B, len=4, overlap=0; bits 1,0,1,1,0,1,1,1,0,1,1
//       -> pulses after bit 4 and after bit 11 only; match_count=2
//  3. Defaults; bits 1,0,1,1 with inp_valid=0 for 3 cycles between each bit
//       -> one seq_seen pulse, exactly 1 cycle after the edge accepting the 4th bit
//  4. cfg_load len=8, pattern=0xA5; stream 0xA5A5 MSB-first, overlap=1
//       -> matches at bits 8 and 16
//     cfg_load cfg_len=9 -> cfg_err pulse; config remains 0xA5/8
//  5. CNT_W=2: 5 matches -> match_count=3, cnt_sat=1
//     cnt_clear asserted with a 6th match -> match_count=0, cnt_sat=0, seq_seen=1
//  6. Drive reset low after bits 1,0,1, release, then send bit 1 -> no pulse
//     Send 1,0,1,1 -> one pulse

Source files
------------

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with a valid-qualified input,
// overlapping/non-overlapping match modes and a saturating match counter.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'h0B,
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1,
    localparam int                LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_valid,
    input  logic               inp_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clear,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat,
    output logic               cfg_err
);

    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] RST_LEN_L = LW'(RST_LEN);

    typedef enum logic {
        FILL   = 1'b0,
        DETECT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [LW-1:0]      len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               seq_seen_q, seq_seen_d;
    logic               cfg_err_q, cfg_err_d;
    logic               cnt_sat_q, cnt_sat_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill_inc;
    logic               accept;
    logic               cfg_ok;
    logic               compare;
    logic               match;

    // A bit presented alongside cfg_load is always discarded, legal config or not.
    assign accept    = inp_valid & ~cfg_load;
    assign hist_next = {hist_q[MAX_LEN-2:0], inp_bit};
    assign fill_inc  = fill_q + 1'b1;
    assign cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // The bit that completes the fill is compared in the same cycle it arrives.
    assign compare = accept && ((state_q == DETECT) || (fill_inc == len_q));
    assign match   = compare && (((hist_next ^ pattern_q) & len_mask) == '0);

    // NOTE: nonblocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            hist_q     <= '0;
            fill_q     <= '0;
            pattern_q  <= RST_PATTERN;
            len_q      <= RST_LEN_L;
            overlap_q  <= RST_OVERLAP;
            seq_seen_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            cnt_sat_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
            seq_seen_q <= seq_seen_d;
            cfg_err_q  <= cfg_err_d;
            cnt_sat_q  <= cnt_sat_d;
            count_q    <= count_d;
        end
    end

    // NOTE: every output of this block takes its hold value first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;

        if (cfg_load) begin
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                hist_d    = '0;
                fill_d    = '0;
                state_d   = FILL;
            end
        end else if (inp_valid) begin
            hist_d = hist_next;
            if (state_q == FILL) begin
                fill_d = fill_inc;
            end
            if (compare) begin
                state_d = DETECT;
            end
            if (match && !overlap_q) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
            end
        end
    end

    always_comb begin
        seq_seen_d = match;
        cfg_err_d  = cfg_load & ~cfg_ok;
        count_d    = count_q;
        cnt_sat_d  = cnt_sat_q;

        if (cnt_clear) begin
            count_d   = '0;
            cnt_sat_d = 1'b0;
        end else begin
            if (match && !(&count_q)) begin
                count_d = count_q + 1'b1;
            end
            cnt_sat_d = cnt_sat_q | (&count_d);
        end
    end

    assign seq_seen    = seq_seen_q;
    assign match_count = count_q;
    assign cnt_sat     = cnt_sat_q;
    assign cfg_err     = cfg_err_q;

endmodule
